mix_stream_checker: RTL and testbench

MIX_STREAM_CHECKER -- requirements
Module: mix_stream_checker

---
 rtl/mix_pkg.sv | 26 ++
 rtl/mix_lane_round.sv | 17 +
 rtl/mix_stream_checker.sv | 177 +++++++++++++++++
 tb/tb_mix_stream_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared definitions for the mixing-stream checker: lane geometry,
// FSM state encoding and the lane seed used at the start of every run.
package mix_pkg;

  localparam int LANES      = 8;
  localparam int LANE_W     = 32;
  localparam int MIX_SHIFT  = 16;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [LANE_W-1:0]     lane_t;
  typedef lane_t [LANES-1:0]     lane_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    MIX,
    COMPARE
  } state_t;

  // Lane i starts every run holding the value i.
  function automatic lane_t lane_seed(input int unsigned i);
    return lane_t'(i);
  endfunction

endpackage

// File: rtl/mix_lane_round.sv
// One combinational mixing round over all eight lanes. Each lane adds
// its left neighbour and folds in a shifted copy of the lane three
// positions ahead; all arithmetic wraps at 32 bits.
module mix_lane_round
  import mix_pkg::*;
(
  input  lane_vec_t lanes_in,
  output lane_vec_t lanes_out
);

  // Every lane is computed from the old lane values in parallel.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lanes_out[g] = (lanes_in[g] + lanes_in[(g + LANES - 1) % LANES])
                        ^ (lanes_in[(g + 3) % LANES] << MIX_SHIFT);
  end

endmodule

// File: rtl/mix_stream_checker.sv
// Stream signature checker. Collects ROUNDS frames of eight 32-bit words,
// accumulating each word into one of eight lanes, mixes the lanes once
// per frame and finally compares the XOR of all lanes against exp_sig.
// Optional idle-input watchdog enabled by defining MIX_CHECKER_TIMEOUT_EN.
module mix_stream_checker
  import mix_pkg::*;
#(
  parameter int unsigned ROUNDS  = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_data,
  input  logic [LANE_W-1:0] exp_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LANE_W-1:0] sig,
  output logic              timeout
);

  state_t    state;
  state_t    state_next;
  lane_vec_t lanes;
  lane_vec_t lanes_mixed;
  lane_idx_t word_idx;
  logic [15:0] frame_cnt;
  lane_t     sig_fold;
  logic      hs;
  logic      last_frame;
  logic      wd_fire;

  assign in_ready   = (state == COLLECT);
  assign busy       = (state != IDLE);
  assign hs         = in_valid && in_ready;
  assign last_frame = (frame_cnt == 16'(ROUNDS - 1));

  mix_lane_round u_round (
    .lanes_in  (lanes),
    .lanes_out (lanes_mixed)
  );

  // Signature is the XOR of all eight lanes.
  always_comb begin
    sig_fold = '0;
    for (int i = 0; i < LANES; i++) begin
      sig_fold = sig_fold ^ lanes[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one stall cycle per frame in MIX, one COMPARE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (wd_fire) begin
          state_next = IDLE;
        end else if (hs && (word_idx == lane_idx_t'(LANES - 1))) begin
          state_next = MIX;
        end
      end
      MIX: begin
        if (last_frame) begin
          state_next = COMPARE;
        end else begin
          state_next = COLLECT;
        end
      end
      COMPARE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Lane accumulation, mixing, frame counting and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes     <= '0;
      word_idx  <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      sig       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < LANES; i++) begin
              lanes[i] <= lane_seed(i);
            end
            word_idx  <= '0;
            frame_cnt <= '0;
            pass      <= 1'b0;
            sig       <= '0;
          end
        end
        COLLECT: begin
          if (wd_fire) begin
            done <= 1'b1;
            pass <= 1'b0;
            sig  <= '0;
          end else if (hs) begin
            lanes[word_idx] <= lanes[word_idx] + in_data;
            word_idx        <= word_idx + 1'b1;
          end
        end
        MIX: begin
          lanes     <= lanes_mixed;
          frame_cnt <= frame_cnt + 1'b1;
        end
        COMPARE: begin
          sig  <= sig_fold;
          pass <= (sig_fold == exp_sig);
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIX_CHECKER_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timeout_q;

  assign wd_fire = (state == COLLECT) && !hs && (wd_cnt == 32'(TIMEOUT - 1));
  assign timeout = timeout_q;

  // Watchdog counts consecutive COLLECT cycles without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (wd_fire) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b1;
    end else if (state == COLLECT) begin
      if (hs) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  // Without the watchdog the abort path never fires and timeout stays 0;
  // TIMEOUT is referenced here only so the parameter remains in use.
  assign wd_fire = 1'b0;
  assign timeout = (TIMEOUT == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_mix_stream_checker.sv
// Directed self-checking bench for mix_stream_checker. Instance A runs
// with ROUNDS=1 (TIMEOUT=4 for the optional watchdog), instance B with
// ROUNDS=2. Expected signatures are hand-computed from the lane rules.
module tb_mix_stream_checker;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a, valid_a, ready_a, busy_a, done_a, pass_a, timeout_a;
  logic [31:0] data_a, exp_a, sig_a;
  logic        start_b, valid_b, ready_b, busy_b, done_b, pass_b, timeout_b;
  logic [31:0] data_b, exp_b, sig_b;

  int nAsserts = 0;
  int nFails   = 0;
  int hsCount, stallCount, busyCount, doneAt;

  mix_stream_checker #(.ROUNDS(1), .TIMEOUT(4)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start_a),
    .in_valid (valid_a),
    .in_ready (ready_a),
    .in_data  (data_a),
    .exp_sig  (exp_a),
    .busy     (busy_a),
    .done     (done_a),
    .pass     (pass_a),
    .sig      (sig_a),
    .timeout  (timeout_a)
  );

  mix_stream_checker #(.ROUNDS(2), .TIMEOUT(64)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .in_valid (valid_b),
    .in_ready (ready_b),
    .in_data  (data_b),
    .exp_sig  (exp_b),
    .busy     (busy_b),
    .done     (done_b),
    .pass     (pass_b),
    .sig      (sig_b),
    .timeout  (timeout_b)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit onB, input logic s, input logic v,
                               input logic [31:0] d, input logic [31:0] e);
    if (onB) begin
      start_b = s; valid_b = v; data_b = d; exp_b = e;
    end else begin
      start_a = s; valid_a = v; data_a = d; exp_a = e;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    stepCycle();
    stepCycle();

    $display("[TB] reset state");
    checkOutput("rst_busy",    32'(busy_a),    0);
    checkOutput("rst_ready",   32'(ready_a),   0);
    checkOutput("rst_done",    32'(done_a),    0);
    checkOutput("rst_pass",    32'(pass_a),    0);
    checkOutput("rst_sig",     sig_a,          0);
    checkOutput("rst_timeout", 32'(timeout_a), 0);
    rst = 1'b0;
    stepCycle();

    // Run 1: one frame of zeros, matching signature, latency check.
    $display("[TB] run 1: zeros, exp 0x8");
    applyStimulus(0, 1, 0, 0, 32'h8);
    stepCycle();
    applyStimulus(0, 0, 1, 0, 32'h8);
    checkOutput("r1_busy_start",  32'(busy_a),  1);
    checkOutput("r1_ready_start", 32'(ready_a), 1);
    for (int w = 0; w < 8; w++) begin
      checkOutput("r1_ready_word", 32'(ready_a), 1);
      stepCycle();
    end
    checkOutput("r1_ready_mix", 32'(ready_a), 0);
    checkOutput("r1_done_e0",   32'(done_a),  0);
    checkOutput("r1_busy_mix",  32'(busy_a),  1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 32'h8);
    checkOutput("r1_done_e1",   32'(done_a),  0);
    stepCycle();
    checkOutput("r1_done_e2",   32'(done_a),  1);
    checkOutput("r1_sig",       sig_a,        32'h8);
    checkOutput("r1_pass",      32'(pass_a),  1);
    checkOutput("r1_busy_idle", 32'(busy_a),  0);
    checkOutput("r1_timeout",   32'(timeout_a), 0);
    stepCycle();
    checkOutput("r1_done_pulse", 32'(done_a), 0);
    checkOutput("r1_sig_held",   sig_a,       32'h8);
    checkOutput("r1_pass_held",  32'(pass_a), 1);

    // Run 2: same stream, mismatching expected signature.
    $display("[TB] run 2: zeros, exp 0x9");
    applyStimulus(0, 1, 0, 0, 32'h9);
    stepCycle();
    checkOutput("r2_pass_clear", 32'(pass_a), 0);
    checkOutput("r2_sig_clear",  sig_a,       0);
    applyStimulus(0, 0, 1, 0, 32'h9);
    for (int w = 0; w < 8; w++) begin
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 32'h9);
    stepCycle();
    stepCycle();
    checkOutput("r2_done", 32'(done_a), 1);
    checkOutput("r2_sig",  sig_a,       32'h8);
    checkOutput("r2_pass", 32'(pass_a), 0);

    // Run 3: start in the done cycle is honoured; start pulses inside
    // COLLECT are ignored. Word 0 is 1, the rest 0 -> sig 0x00010004.
    $display("[TB] run 3: start on done, start pulses during collect");
    applyStimulus(0, 1, 0, 0, 32'h0001_0004);
    stepCycle();
    checkOutput("r3_busy_restart", 32'(busy_a), 1);
    checkOutput("r3_sig_clear",    sig_a,       0);
    for (int w = 0; w < 8; w++) begin
      applyStimulus(0, (w >= 1 && w <= 3), 1, (w == 0) ? 32'h1 : 32'h0, 32'h0001_0004);
      checkOutput("r3_ready_word", 32'(ready_a), 1);
      stepCycle();
    end
    checkOutput("r3_ready_mix", 32'(ready_a), 0);
    applyStimulus(0, 0, 0, 0, 32'h0001_0004);
    stepCycle();
    stepCycle();
    checkOutput("r3_done", 32'(done_a), 1);
    checkOutput("r3_sig",  sig_a,       32'h0001_0004);
    checkOutput("r3_pass", 32'(pass_a), 1);
    stepCycle();

    // Run 4: reset after three accepted words, then a clean rerun.
    $display("[TB] run 4: reset mid-run then rerun");
    applyStimulus(0, 1, 0, 0, 32'h8);
    stepCycle();
    applyStimulus(0, 0, 1, 0, 32'h8);
    for (int w = 0; w < 3; w++) begin
      stepCycle();
      checkOutput("r4_no_done", 32'(done_a), 0);
    end
    rst = 1'b1;
    stepCycle();
    checkOutput("r4_rst_busy",  32'(busy_a),  0);
    checkOutput("r4_rst_ready", 32'(ready_a), 0);
    checkOutput("r4_rst_done",  32'(done_a),  0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h8);
    stepCycle();
    checkOutput("r4_idle_done", 32'(done_a), 0);
    applyStimulus(0, 1, 0, 0, 32'h8);
    stepCycle();
    applyStimulus(0, 0, 1, 0, 32'h8);
    for (int w = 0; w < 8; w++) begin
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 32'h8);
    stepCycle();
    stepCycle();
    checkOutput("r4_done", 32'(done_a), 1);
    checkOutput("r4_sig",  sig_a,       32'h8);
    checkOutput("r4_pass", 32'(pass_a), 1);

    // Run 5: two frames with in_valid held high on instance B.
    $display("[TB] run 5: ROUNDS=2 streaming");
    applyStimulus(1, 1, 0, 0, 0);
    stepCycle();
    applyStimulus(1, 0, 1, 0, 0);
    hsCount = 0; stallCount = 0; busyCount = 0; doneAt = -1;
    for (int c = 0; c < 40; c++) begin
      if (done_b) begin
        doneAt = c;
        break;
      end
      if (busy_b) busyCount++;
      if (ready_b) hsCount++;
      else if (hsCount > 0 && hsCount < 16) stallCount++;
      stepCycle();
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("r5_handshakes", 32'(hsCount),    16);
    checkOutput("r5_stall",      32'(stallCount), 1);
    checkOutput("r5_busy_cycles", 32'(busyCount), 19);
    checkOutput("r5_done_at",    32'(doneAt),     19);

`ifdef MIX_CHECKER_TIMEOUT_EN
    // Run 6: watchdog aborts after four idle COLLECT cycles.
    $display("[TB] run 6: watchdog");
    applyStimulus(0, 1, 0, 0, 32'h8);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 32'h8);
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("r6_still_busy", 32'(busy_a), 1);
      checkOutput("r6_no_done",    32'(done_a), 0);
    end
    stepCycle();
    checkOutput("r6_done",    32'(done_a),    1);
    checkOutput("r6_timeout", 32'(timeout_a), 1);
    checkOutput("r6_pass",    32'(pass_a),    0);
    checkOutput("r6_sig",     sig_a,          0);
    checkOutput("r6_busy",    32'(busy_a),    0);
    stepCycle();
    checkOutput("r6_done_pulse",   32'(done_a),    0);
    checkOutput("r6_timeout_held", 32'(timeout_a), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
